// File: rtl/mining_job_ctrl.sv
// Job sequencer between the UART byte streams and the SHA-256 miner core.
// Loads a framed header into the core's header RAM, starts the nonce sweep,
// and returns a 6-byte result frame once the core reports completion.
module mining_job_ctrl #(
  parameter int unsigned HDR_BYTES  = 76,
  parameter logic [7:0]  SYNC_BYTE  = 8'hAA,
  parameter logic [7:0]  RESP_BYTE  = 8'h55,
  parameter int unsigned RX_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  output logic        hdr_wr_en,
  output logic [6:0]  hdr_wr_addr,
  output logic [7:0]  hdr_wr_data,
  output logic        core_start,
  output logic        core_abort,
  input  logic        core_done,
  input  logic        core_found,
  input  logic [31:0] core_nonce,
  output logic [2:0]  state_dbg,
  output logic [15:0] job_count,
  output logic [7:0]  err_count
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_START = 3'd2,
    S_MINE  = 3'd3,
    S_RESP  = 3'd4
  } state_t;

  localparam int unsigned TW      = $clog2(RX_TIMEOUT + 1);
  localparam logic [6:0]  IDX_END = 7'(HDR_BYTES);
  localparam logic [6:0]  TX_LAST = 7'd5;
  localparam logic [TW-1:0] TMO   = TW'(RX_TIMEOUT);

  state_t        state_q, state_d;
  logic [6:0]    idx_q, idx_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          found_q, found_d;
  logic [31:0]   nonce_q, nonce_d;
  logic          wr_en_q, wr_en_d;
  logic [6:0]    wr_addr_q, wr_addr_d;
  logic [7:0]    wr_data_q, wr_data_d;
  logic          abort_q, abort_d;
  logic [15:0]   job_q, job_d;
  logic [7:0]    err_q, err_d;
  logic [7:0]    tx_byte;

  wire sync_rx = rx_valid && (rx_data == SYNC_BYTE);

  // Next-state and register-update logic for the job sequencer.
  // idx doubles as the header byte index in LOAD and the TX byte index in RESP.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    timer_d   = timer_q;
    found_d   = found_q;
    nonce_d   = nonce_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    abort_d   = 1'b0;
    job_d     = job_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE: begin
        if (sync_rx) begin
          state_d = S_LOAD;
          idx_d   = '0;
          timer_d = '0;
        end
      end
      S_LOAD: begin
        if (idx_q == IDX_END) begin
          state_d = S_START;
        end else if (rx_valid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = idx_q;
          wr_data_d = rx_data;
          idx_d     = idx_q + 7'd1;
          timer_d   = '0;
        end else if (timer_q == TMO) begin
          state_d = S_IDLE;
          if (err_q != '1) err_d = err_q + 8'd1;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      S_START: state_d = S_MINE;
      S_MINE: begin
        if (core_done) begin
          found_d = core_found;
          nonce_d = core_nonce;
          idx_d   = '0;
          state_d = S_RESP;
        end else if (sync_rx) begin
          abort_d = 1'b1;
          idx_d   = '0;
          timer_d = '0;
          state_d = S_LOAD;
        end
      end
      S_RESP: begin
        if (tx_ready) begin
          if (idx_q == TX_LAST) begin
            state_d = S_IDLE;
            if (job_q != '1) job_d = job_q + 16'd1;
          end else begin
            idx_d = idx_q + 7'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      timer_q   <= '0;
      found_q   <= 1'b0;
      nonce_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      abort_q   <= 1'b0;
      job_q     <= '0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      timer_q   <= timer_d;
      found_q   <= found_d;
      nonce_q   <= nonce_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      abort_q   <= abort_d;
      job_q     <= job_d;
      err_q     <= err_d;
    end
  end

  // Result frame byte selection; forced to zero outside RESP.
  always_comb begin
    tx_byte = '0;
    if (state_q == S_RESP) begin
      case (idx_q[2:0])
        3'd0:    tx_byte = RESP_BYTE;
        3'd1:    tx_byte = {7'd0, found_q};
        3'd2:    tx_byte = nonce_q[31:24];
        3'd3:    tx_byte = nonce_q[23:16];
        3'd4:    tx_byte = nonce_q[15:8];
        default: tx_byte = nonce_q[7:0];
      endcase
    end
  end

  assign tx_data     = tx_byte;
  assign tx_valid    = (state_q == S_RESP);
  assign hdr_wr_en   = wr_en_q;
  assign hdr_wr_addr = wr_addr_q;
  assign hdr_wr_data = wr_data_q;
  assign core_start  = (state_q == S_START);
  assign core_abort  = abort_q;
  assign state_dbg   = state_q;
  assign job_count   = job_q;
  assign err_count   = err_q;

endmodule

// File: tb/tb_mining_job_ctrl.sv
// Bench for mining_job_ctrl: table of result-frame vectors, hand-written
// corner sequences and randomized jobs checked against a frame-level model.
module tb_mining_job_ctrl;

  localparam int unsigned HDR = 76;
  localparam int unsigned TO  = 200;

  logic        clk, reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [7:0]  tx_data;
  logic        tx_valid, tx_ready;
  logic        hdr_wr_en;
  logic [6:0]  hdr_wr_addr;
  logic [7:0]  hdr_wr_data;
  logic        core_start, core_abort, core_done, core_found;
  logic [31:0] core_nonce;
  logic [2:0]  state_dbg;
  logic [15:0] job_count;
  logic [7:0]  err_count;

  mining_job_ctrl #(
    .HDR_BYTES(HDR), .SYNC_BYTE(8'hAA), .RESP_BYTE(8'h55), .RX_TIMEOUT(TO)
  ) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .hdr_wr_en(hdr_wr_en), .hdr_wr_addr(hdr_wr_addr), .hdr_wr_data(hdr_wr_data),
    .core_start(core_start), .core_abort(core_abort), .core_done(core_done),
    .core_found(core_found), .core_nonce(core_nonce), .state_dbg(state_dbg),
    .job_count(job_count), .err_count(err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          errors = 0;
  int          checks = 0;
  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Monitor state
  logic [7:0]  ram_seen [128];
  int          wr_cnt = 0, bad_addr = 0, starts = 0, aborts = 0;
  int unsigned start_cyc = 0, first_tx_cyc = 0, last_rx_cyc = 0, done_cyc = 0;
  logic [7:0]  txq [$];
  logic        prev_valid = 1'b0, prev_ready = 1'b0;
  logic [7:0]  prev_data = '0;

  // Model state
  logic [7:0]  hdr_tx [HDR];
  int          exp_jobs = 0;

  typedef struct {
    bit          found;
    logic [31:0] nonce;
    int          mode;
    logic [47:0] expf;
  } vec_t;
  vec_t vt [4];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [47:0] frame(input bit f, input logic [31:0] n);
    logic [7:0] b [6];
    b[0] = 8'h55;
    b[1] = f ? 8'h01 : 8'h00;
    for (int i = 0; i < 4; i++) b[2+i] = 8'((n >> (24 - 8*i)) & 32'hFF);
    return {b[0], b[1], b[2], b[3], b[4], b[5]};
  endfunction

  // Observe DUT outputs mid-cycle.
  always @(negedge clk) begin
    if (!reset) begin
      prev_valid = 1'b0;
      prev_ready = 1'b0;
    end else begin
      if (hdr_wr_en) begin
        ram_seen[hdr_wr_addr] = hdr_wr_data;
        wr_cnt++;
        if (hdr_wr_addr >= 7'(HDR)) bad_addr++;
      end
      if (core_start) begin starts++; start_cyc = cyc; end
      if (core_abort) aborts++;
      if (tx_valid && !prev_valid) first_tx_cyc = cyc;
      if (prev_valid && !prev_ready) check("tx_hold", {55'd0, tx_valid, tx_data}, {55'd0, 1'b1, prev_data});
      if (tx_valid && tx_ready) txq.push_back(tx_data);
      prev_valid = tx_valid;
      prev_ready = tx_ready;
      prev_data  = tx_data;
    end
  end

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    last_rx_cyc = cyc;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic rand_header();
    for (int i = 0; i < HDR; i++)
      hdr_tx[i] = ($urandom_range(0, 7) == 0) ? 8'hAA : 8'($urandom_range(0, 255));
  endtask

  task automatic load_frame(input bit with_sync, input int gapmax);
    int s0, mism;
    for (int i = 0; i < 128; i++) ram_seen[i] = 'x;
    wr_cnt = 0;
    bad_addr = 0;
    s0 = starts;
    if (with_sync) send_byte(8'hAA);
    for (int i = 0; i < HDR; i++) begin
      step($urandom_range(0, gapmax));
      send_byte(hdr_tx[i]);
    end
    step(3);
    mism = 0;
    for (int i = 0; i < HDR; i++) if (ram_seen[i] !== hdr_tx[i]) mism++;
    check("hdr_writes", 64'(wr_cnt), 64'(HDR));
    check("hdr_data_mismatches", 64'(mism), 64'd0);
    check("hdr_addr_range", 64'(bad_addr), 64'd0);
    check("start_count", 64'(starts - s0), 64'd1);
    check("start_latency", 64'(start_cyc - last_rx_cyc), 64'd2);
    check("state_mine", 64'(state_dbg), 64'd3);
  endtask

  task automatic drive_done(input bit f, input logic [31:0] n);
    txq.delete();
    core_done  = 1'b1;
    core_found = f;
    core_nonce = n;
    done_cyc   = cyc;
    step();
    core_done  = 1'b0;
    core_found = 1'b0;
    core_nonce = '0;
  endtask

  task automatic collect(input int mode, output logic [47:0] got);
    for (int c = 0; c < 400 && txq.size() < 6; c++) begin
      case (mode)
        0:       tx_ready = 1'b1;
        1:       tx_ready = (cyc % 3 == 0);
        default: tx_ready = 1'($urandom_range(0, 1));
      endcase
      step();
    end
    tx_ready = 1'b0;
    check("resp_bytes", 64'(txq.size()), 64'd6);
    got = '0;
    for (int i = 0; i < 6 && i < txq.size(); i++) got = {got[39:0], txq[i]};
    check("first_tx_latency", 64'(first_tx_cyc - done_cyc), 64'd1);
    @(negedge clk);
    check("tx_valid_drop", 64'(tx_valid), 64'd0);
    check("state_idle", 64'(state_dbg), 64'd0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [47:0] got;
    int a0, s0;
    bit f;
    logic [31:0] n;

    vt[0] = '{found: 1'b1, nonce: 32'h1234ABCD, mode: 0, expf: 48'h5501_1234ABCD};
    vt[1] = '{found: 1'b1, nonce: 32'h1234ABCD, mode: 1, expf: 48'h5501_1234ABCD};
    vt[2] = '{found: 1'b0, nonce: 32'hFFFFFFFF, mode: 2, expf: 48'h5500_FFFFFFFF};
    vt[3] = '{found: 1'b1, nonce: 32'h00000000, mode: 1, expf: 48'h5501_00000000};

    reset = 1'b0; rx_valid = 1'b0; rx_data = '0; tx_ready = 1'b0;
    core_done = 1'b0; core_found = 1'b0; core_nonce = '0;
    step(3);
    check("rst_state", 64'(state_dbg), 64'd0);
    check("rst_outputs", {tx_valid, hdr_wr_en, core_start, core_abort, tx_data}, 64'd0);
    check("rst_counters", {job_count, err_count}, 64'd0);
    reset = 1'b1;
    step(2);

    // Ignored bytes in IDLE
    send_byte(8'h13); send_byte(8'h55);
    step(2);
    check("idle_ignore", 64'(state_dbg), 64'd0);

    // Table-driven result frames
    for (int v = 0; v < 4; v++) begin
      if (v == 0) for (int i = 0; i < HDR; i++) hdr_tx[i] = 8'(i);
      else rand_header();
      load_frame(1'b1, v);
      drive_done(vt[v].found, vt[v].nonce);
      collect(vt[v].mode, got);
      exp_jobs++;
      check("tbl_frame", 64'(got), 64'(vt[v].expf));
      check("tbl_jobs", 64'(job_count), 64'(exp_jobs));
    end

    // Inter-byte timeout drops the frame
    s0 = starts;
    wr_cnt = 0;
    send_byte(8'hAA);
    for (int i = 0; i < 10; i++) send_byte(8'(i + 1));
    step(TO / 2);
    check("tmo_still_load", 64'(state_dbg), 64'd1);
    step(TO + 10);
    check("tmo_idle", 64'(state_dbg), 64'd0);
    check("tmo_err", 64'(err_count), 64'd1);
    check("tmo_no_start", 64'(starts - s0), 64'd0);
    check("tmo_writes", 64'(wr_cnt), 64'd10);

    // SYNC during MINE aborts and reloads
    rand_header();
    load_frame(1'b1, 0);
    txq.delete();
    a0 = aborts;
    send_byte(8'h42);
    send_byte(8'hAA);
    step();
    check("abort_pulse", 64'(aborts - a0), 64'd1);
    check("abort_state", 64'(state_dbg), 64'd1);
    check("abort_no_tx", 64'(txq.size()), 64'd0);
    rand_header();
    load_frame(1'b0, 1);
    drive_done(1'b0, 32'hCAFE0001);
    collect(0, got);
    exp_jobs++;
    check("abort_frame", 64'(got), 64'(frame(1'b0, 32'hCAFE0001)));

    // core_done and SYNC in the same cycle: done wins
    rand_header();
    load_frame(1'b1, 0);
    a0 = aborts;
    rx_valid = 1'b1; rx_data = 8'hAA;
    drive_done(1'b1, 32'h0BADF00D);
    rx_valid = 1'b0;
    collect(2, got);
    exp_jobs++;
    check("simul_no_abort", 64'(aborts - a0), 64'd0);
    check("simul_frame", 64'(got), 64'(frame(1'b1, 32'h0BADF00D)));

    // Randomized jobs
    for (int j = 0; j < 8; j++) begin
      for (int k = 0; k < 3; k++) send_byte(8'($urandom_range(0, 8'hA9)));
      rand_header();
      load_frame(1'b1, 2);
      a0 = aborts;
      for (int k = 0; k < int'($urandom_range(0, 3)); k++) send_byte(8'($urandom_range(0, 8'hA9)));
      f = 1'($urandom_range(0, 1));
      n = $urandom;
      drive_done(f, n);
      collect(2, got);
      exp_jobs++;
      check("rnd_no_abort", 64'(aborts - a0), 64'd0);
      check("rnd_frame", 64'(got), 64'(frame(f, n)));
      check("rnd_jobs", 64'(job_count), 64'(exp_jobs));
    end
    check("rnd_err_kept", 64'(err_count), 64'd1);

    // Reset in the middle of RESP
    rand_header();
    load_frame(1'b1, 0);
    drive_done(1'b1, 32'h89ABCDEF);
    for (int c = 0; c < 100 && txq.size() < 3; c++) begin
      tx_ready = 1'b1;
      step();
    end
    check("mid_resp_bytes", 64'(txq.size()), 64'd3);
    check("mid_resp_valid", 64'(tx_valid), 64'd1);
    a0 = aborts;
    reset = 1'b0;
    #1;
    check("rst_tx_valid", 64'(tx_valid), 64'd0);
    check("rst_state_mid", 64'(state_dbg), 64'd0);
    check("rst_counters_mid", {job_count, err_count}, 64'd0);
    check("rst_no_abort", 64'(core_abort), 64'd0);
    tx_ready = 1'b0;
    step(2);
    reset = 1'b1;
    step(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
